pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the MIPS datapath. It replaces the hand-written per-stage latches (ID/EX style) with one block.
- Carries a PC, an opaque data payload and an opaque control word, each of configurable width.
- Adds valid/ready backpressure through a 2-entry skid buffer, hazard bubble injection, flush, and saturating stall/bubble statistics counters for the debug unit.

Parameters:
- PC_W, 32, width of the PC field.
- DATA_W, 133, width of the data payload (concatenated operands, immediate, register indices).
- CTRL_W, 16, width of the control word.
- NOP_CTRL, 16'h0000, control word written when a bubble is injected (stage-specific NOP encoding).
- CNT_W, 16, width of the statistics counters.
- NEG_EDGE, 1, 1 = all registers update on falling clk edge; 0 = rising edge.

Ports:
- clk  in  1  clock; the active edge is selected by NEG_EDGE.
- rst  in  1  reset: synchronous, active-high.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  stage can accept a beat; registered, equals ~skid_full.
- i_pc  in  PC_W  upstream PC.
- i_data  in  DATA_W  upstream payload.
- i_ctrl  in  CTRL_W  upstream control word.
- i_bubble  in  1  hazard unit requests a NOP in place of the current beat.
- i_flush  in  1  discard all held contents (branch/jump taken).
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the output beat.
- o_pc  out  PC_W  output PC.
- o_data  out  DATA_W  output payload.
- o_ctrl  out  CTRL_W  output control word.
- o_stall_cnt  out  CNT_W  cycles with o_valid & ~i_ready, saturating.
- o_bubble_cnt  out  CNT_W  bubbles injected, saturating.

Behaviour:
- Storage: a main register (drives the outputs) plus one skid entry. All updates occur on the active edge only.
- Reset (synchronous, rst=1 at the active edge) clears:
  - o_valid, skid_full, o_pc, o_data and both counters to 0.
  - o_ctrl to 0, not NOP_CTRL.
  - o_ready to 0 while rst is asserted; it becomes 1 on the first active edge after rst deasserts.
- Handshake definitions:
  - accept = i_valid & o_ready & ~i_bubble & ~i_flush.
  - drain = ~o_valid | i_ready.
  - Upstream must hold its beat stable until accept.
- Bubble: if i_bubble & o_ready & ~i_flush, the stage loads the entry {pc=i_pc, data=0, ctrl=NOP_CTRL} as a valid beat.
  - i_valid is ignored and the upstream beat is not consumed.
  - o_bubble_cnt increments.
  - The PC passes through so the exception/debug path still sees the address.
- Loaded entry L is the accepted beat or the bubble entry.
- Main register and skid update rules, when L exists:
  - drain & ~skid_full: main <= L.
  - drain & skid_full: main <= skid, skid <= L.
  - ~drain: skid <= L and skid_full <= 1. This cannot occur when skid_full=1, because o_ready=0 then.
- Main register and skid update rules, with no L:
  - drain & skid_full: main <= skid, skid_full <= 0.
  - drain & ~skid_full: o_valid <= 0; main contents are kept.
- Ordering: beats are delivered strictly in acceptance order. No beat is lost or duplicated under any i_ready pattern.
- Latency and throughput:
  - One active edge from accept to o_valid when the stage is unstalled.
  - Throughput is 1 beat per cycle with i_ready held high.
- Flush: has priority over everything else.
  - At the active edge with i_flush=1: o_valid<=0, skid_full<=0, o_ctrl<=NOP_CTRL, o_data<=0; o_pc is kept.
  - A beat presented in the same cycle is dropped, not accepted.
  - Counters are not cleared.
- Counters:
  - o_stall_cnt increments on every active edge where o_valid=1 & i_ready=0 & ~i_flush.
  - Both counters saturate at all-ones; there is no wrap-around.
- Simultaneous bubble + flush: flush wins; no bubble is counted.
- Reset during a stall or with skid_full=1: all contents are discarded and the reset values above apply.

Decomposition:
- Shared package pipe_pkg holds:
  - per-stage widths (ID_EX_DATA_W, EX_MEM_DATA_W, ...);
  - per-stage NOP control constants (the ID/EX NOP is RegDst=01, ALUOp=011, all else 0);
  - the ctrl-word field offsets.
- One natural sub-module: sat_counter (CNT_W parameter, inc, rst), instantiated twice.
- The edge selection is a generate on NEG_EDGE inside pipe_stage_reg.

Test Plan:
- Streaming: i_ready=1, i_valid=1 for 8 beats with PC 0x00..0x1C → identical beats appear one edge later, o_valid continuous, o_stall_cnt=0.
- Backpressure: i_ready=0 for 3 edges mid-stream → o_ready falls after 2 beats are held, order is preserved on release, o_stall_cnt=3.
- Bubble: i_bubble=1 for 1 cycle with i_pc=0x40, i_valid=1 → output {0x40, data=0, ctrl=NOP_CTRL}, then the held beat 0x40 with its real data follows, o_bubble_cnt=1.
- Flush with skid_full=1 and i_valid=1 → next edge o_valid=0, o_ready=1, the presented beat never appears, counters unchanged.
- Saturation with CNT_W=4: 20 stalled cycles → o_stall_cnt=15, then it holds.
- Reset mid-stall with NEG_EDGE=1 and 0 (two runs) → all outputs 0 and o_ready=0 during rst; o_ready=1 one active edge after release; no update on the inactive edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: per-stage payload widths, control-word field
// layout and the NOP control encodings loaded when a stage injects a bubble.
package pipe_pkg;

  localparam int IF_ID_DATA_W  = 32;
  localparam int ID_EX_DATA_W  = 133;
  localparam int EX_MEM_DATA_W = 107;
  localparam int MEM_WB_DATA_W = 71;

  localparam int PIPE_CTRL_W = 16;

  // Control-word field offsets (LSB positions).
  localparam int CTRL_REGDST_LSB   = 0;
  localparam int CTRL_REGDST_W     = 2;
  localparam int CTRL_ALUOP_LSB    = 2;
  localparam int CTRL_ALUOP_W      = 3;
  localparam int CTRL_ALUSRC_BIT   = 5;
  localparam int CTRL_MEMREAD_BIT  = 6;
  localparam int CTRL_MEMWRITE_BIT = 7;
  localparam int CTRL_MEMTOREG_BIT = 8;
  localparam int CTRL_REGWRITE_BIT = 9;
  localparam int CTRL_BRANCH_BIT   = 10;
  localparam int CTRL_JUMP_BIT     = 11;

  typedef enum logic [CTRL_REGDST_W-1:0] {
    REGDST_RT = 2'b00,
    REGDST_RD = 2'b01,
    REGDST_RA = 2'b10
  } regdst_e;

  typedef enum logic [CTRL_ALUOP_W-1:0] {
    ALUOP_ADD   = 3'b000,
    ALUOP_SUB   = 3'b001,
    ALUOP_RTYPE = 3'b010,
    ALUOP_NOP   = 3'b011,
    ALUOP_LOGIC = 3'b100
  } aluop_e;

  // Builds a control word with only the register-destination and ALU fields set.
  function automatic logic [PIPE_CTRL_W-1:0] pack_alu_ctrl(input regdst_e rd, input aluop_e op);
    logic [PIPE_CTRL_W-1:0] w;
    w = '0;
    w[CTRL_REGDST_LSB +: CTRL_REGDST_W] = rd;
    w[CTRL_ALUOP_LSB +: CTRL_ALUOP_W]   = op;
    return w;
  endfunction

  // ID/EX NOP: RegDst=01, ALUOp=011, no write enables.
  localparam logic [PIPE_CTRL_W-1:0] ID_EX_NOP_CTRL  = 16'h000D;
  localparam logic [PIPE_CTRL_W-1:0] EX_MEM_NOP_CTRL = 16'h0000;
  localparam logic [PIPE_CTRL_W-1:0] MEM_WB_NOP_CTRL = 16'h0000;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter for the stage statistics; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: main register plus one skid entry,
// bubble injection, flush and saturating stall/bubble statistics.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              DATA_W   = 133,
  parameter int              CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] NOP_CTRL = 16'h0000,
  parameter int              CNT_W    = 16,
  parameter bit              NEG_EDGE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_bubble,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [PC_W-1:0]   o_pc,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  // Handshake: upstream beat moves when i_valid & o_ready (and no bubble/flush);
  // the output beat moves when o_valid & i_ready. Both sides hold until then.
  logic clk_act;
  if (NEG_EDGE) begin : g_neg_edge
    assign clk_act = ~clk;
  end else begin : g_pos_edge
    assign clk_act = clk;
  end

  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              skid_full_q, skid_full_d;
  logic [PC_W-1:0]   pc_q, pc_d, skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] data_q, data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d, skid_ctrl_q, skid_ctrl_d;

  logic              take_bubble, accept, load, drain, stall_inc;
  logic [DATA_W-1:0] l_data;
  logic [CTRL_W-1:0] l_ctrl;

  assign take_bubble = i_bubble & ready_q & ~i_flush;
  assign accept      = i_valid & ready_q & ~i_bubble & ~i_flush;
  assign load        = accept | take_bubble;
  assign drain       = ~valid_q | i_ready;
  assign stall_inc   = valid_q & ~i_ready & ~i_flush;
  assign l_data      = take_bubble ? '0 : i_data;
  assign l_ctrl      = take_bubble ? NOP_CTRL : i_ctrl;

  always_comb begin
    valid_d     = valid_q;
    skid_full_d = skid_full_q;
    pc_d        = pc_q;
    data_d      = data_q;
    ctrl_d      = ctrl_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (i_flush) begin
      valid_d     = 1'b0;
      skid_full_d = 1'b0;
      data_d      = '0;
      ctrl_d      = NOP_CTRL;
    end else if (load) begin
      if (drain && !skid_full_q) begin
        valid_d = 1'b1;
        pc_d    = i_pc;
        data_d  = l_data;
        ctrl_d  = l_ctrl;
      end else begin
        // Either the output is stalled or the skid drains first; L parks in skid.
        if (drain) begin
          valid_d = 1'b1;
          pc_d    = skid_pc_q;
          data_d  = skid_data_q;
          ctrl_d  = skid_ctrl_q;
        end
        skid_full_d = 1'b1;
        skid_pc_d   = i_pc;
        skid_data_d = l_data;
        skid_ctrl_d = l_ctrl;
      end
    end else if (drain) begin
      if (skid_full_q) begin
        valid_d     = 1'b1;
        skid_full_d = 1'b0;
        pc_d        = skid_pc_q;
        data_d      = skid_data_q;
        ctrl_d      = skid_ctrl_q;
      end else begin
        valid_d = 1'b0;
      end
    end
    ready_d = ~skid_full_d;
  end

  always_ff @(posedge clk_act) begin
    if (rst) begin
      valid_q     <= 1'b0;
      ready_q     <= 1'b0;
      skid_full_q <= 1'b0;
      pc_q        <= '0;
      data_q      <= '0;
      ctrl_q      <= '0;
      skid_pc_q   <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      skid_full_q <= skid_full_d;
      pc_q        <= pc_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      skid_pc_q   <= skid_pc_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_act),
    .rst_i (rst),
    .inc_i (stall_inc),
    .cnt_o (o_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_act),
    .rst_i (rst),
    .inc_i (take_bubble),
    .cnt_o (o_bubble_cnt)
  );

  assign o_valid = valid_q;
  assign o_ready = ready_q;
  assign o_pc    = pc_q;
  assign o_data  = data_q;
  assign o_ctrl  = ctrl_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: falling-edge ID/EX-sized stage plus a rising-edge stage with
// 4-bit counters for saturation and reset-edge checks.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int PW  = 32;
  localparam int DW  = 133;
  localparam int CW  = 16;
  localparam int DWP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // falling-edge instance
  logic          n_rst, n_valid, n_ready, n_bubble, n_flush, n_ovalid, n_iready;
  logic [PW-1:0] n_pc, n_opc;
  logic [DW-1:0] n_data, n_odata;
  logic [CW-1:0] n_ctrl, n_octrl;
  logic [15:0]   n_stall, n_bcnt;

  // rising-edge instance
  logic           p_rst, p_valid, p_ready, p_bubble, p_flush, p_ovalid, p_iready;
  logic [PW-1:0]  p_pc, p_opc;
  logic [DWP-1:0] p_data, p_odata;
  logic [CW-1:0]  p_ctrl, p_octrl;
  logic [3:0]     p_stall, p_bcnt;

  pipe_stage_reg #(.PC_W(PW), .DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(ID_EX_NOP_CTRL),
                   .CNT_W(16), .NEG_EDGE(1'b1)) dut_n (
    .clk(clk), .rst(n_rst), .i_valid(n_valid), .o_ready(n_ready), .i_pc(n_pc),
    .i_data(n_data), .i_ctrl(n_ctrl), .i_bubble(n_bubble), .i_flush(n_flush),
    .o_valid(n_ovalid), .i_ready(n_iready), .o_pc(n_opc), .o_data(n_odata),
    .o_ctrl(n_octrl), .o_stall_cnt(n_stall), .o_bubble_cnt(n_bcnt)
  );

  pipe_stage_reg #(.PC_W(PW), .DATA_W(DWP), .CTRL_W(CW), .NOP_CTRL(ID_EX_NOP_CTRL),
                   .CNT_W(4), .NEG_EDGE(1'b0)) dut_p (
    .clk(clk), .rst(p_rst), .i_valid(p_valid), .o_ready(p_ready), .i_pc(p_pc),
    .i_data(p_data), .i_ctrl(p_ctrl), .i_bubble(p_bubble), .i_flush(p_flush),
    .o_valid(p_ovalid), .i_ready(p_iready), .o_pc(p_opc), .o_data(p_odata),
    .o_ctrl(p_octrl), .o_stall_cnt(p_stall), .o_bubble_cnt(p_bcnt)
  );

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step_n();
    @(negedge clk); #1;
  endtask

  task automatic step_p();
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] mk_data(input int k);
    return {5'(k), 64'hA5A5_0000_0000_0000 | 64'(k), 64'h1234_5678_9ABC_0000 | 64'(k)};
  endfunction

  function automatic logic [CW-1:0] mk_ctrl(input int k);
    return 16'hC000 | 16'(k);
  endfunction

  task automatic drive_n(input logic v, input logic [PW-1:0] pc, input int k);
    n_valid = v;
    n_pc    = pc;
    n_data  = mk_data(k);
    n_ctrl  = mk_ctrl(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst = 1'b1; n_valid = 1'b0; n_pc = '0; n_data = '0; n_ctrl = '0;
    n_bubble = 1'b0; n_flush = 1'b0; n_iready = 1'b0;
    p_rst = 1'b1; p_valid = 1'b0; p_pc = '0; p_data = '0; p_ctrl = '0;
    p_bubble = 1'b0; p_flush = 1'b0; p_iready = 1'b0;
    #1;

    // reset state
    step_n(); step_n();
    check("rst_valid", n_ovalid, 0);
    check("rst_ready", n_ready, 0);
    check("rst_pc", n_opc, 0);
    check("rst_data", n_odata, 0);
    check("rst_ctrl", n_octrl, 0);
    check("rst_stall", n_stall, 0);
    check("rst_bcnt", n_bcnt, 0);
    n_rst = 1'b0;
    step_n();
    check("rel_ready", n_ready, 1);
    check("rel_valid", n_ovalid, 0);

    // nothing moves on the rising (inactive) edge
    n_iready = 1'b1;
    drive_n(1'b1, 32'h200, 99);
    @(posedge clk); #1;
    check("n_inactive_valid", n_ovalid, 0);
    step_n();
    check("n_active_valid", n_ovalid, 1);
    check("n_active_pc", n_opc, 32'h200);
    n_valid = 1'b0;
    step_n();
    check("n_idle_valid", n_ovalid, 0);

    // streaming, one beat per edge
    for (int k = 0; k < 8; k++) begin
      drive_n(1'b1, 32'(k * 4), k);
      step_n();
      check("str_valid", n_ovalid, 1);
      check("str_pc", n_opc, 32'(k * 4));
      check("str_data", n_odata, mk_data(k));
      check("str_ctrl", n_octrl, mk_ctrl(k));
      check("str_ready", n_ready, 1);
    end
    n_valid = 1'b0;
    step_n();
    check("str_end_valid", n_ovalid, 0);
    check("str_stall", n_stall, 0);

    // backpressure: A in main, B in skid, C held upstream
    drive_n(1'b1, 32'h100, 20); exp_q.push_back(32'h100);
    step_n();
    check("bp_a_pc", n_opc, exp_q.pop_front());
    n_iready = 1'b0;
    drive_n(1'b1, 32'h104, 21); exp_q.push_back(32'h104);
    step_n();
    check("bp_ready_low", n_ready, 0);
    check("bp_hold_pc", n_opc, 32'h100);
    drive_n(1'b1, 32'h108, 22); exp_q.push_back(32'h108);
    step_n(); step_n();
    check("bp_stall3", n_stall, 3);
    check("bp_still_low", n_ready, 0);
    n_iready = 1'b1;
    step_n();
    check("bp_b_pc", n_opc, exp_q.pop_front());
    check("bp_b_data", n_odata, mk_data(21));
    check("bp_ready_back", n_ready, 1);
    step_n();
    check("bp_c_pc", n_opc, exp_q.pop_front());
    check("bp_c_data", n_odata, mk_data(22));
    n_valid = 1'b0;
    step_n();
    check("bp_end_valid", n_ovalid, 0);
    check("bp_stall_final", n_stall, 3);
    check("bp_q_empty", exp_q.size(), 0);

    // bubble then the held beat
    drive_n(1'b1, 32'h40, 30);
    n_bubble = 1'b1;
    step_n();
    check("bub_valid", n_ovalid, 1);
    check("bub_pc", n_opc, 32'h40);
    check("bub_data", n_odata, 0);
    check("bub_ctrl", n_octrl, 16'h000D);
    check("bub_cnt", n_bcnt, 1);
    n_bubble = 1'b0;
    step_n();
    check("bub_beat_pc", n_opc, 32'h40);
    check("bub_beat_data", n_odata, mk_data(30));
    check("bub_beat_ctrl", n_octrl, mk_ctrl(30));
    check("bub_cnt_hold", n_bcnt, 1);
    n_valid = 1'b0;
    step_n();

    // flush with skid full and a beat presented
    drive_n(1'b1, 32'h80, 40);
    step_n();
    n_iready = 1'b0;
    drive_n(1'b1, 32'h84, 41);
    step_n();
    check("fl_skid_full", n_ready, 0);
    check("fl_stall_pre", n_stall, 4);
    drive_n(1'b1, 32'h88, 42);
    n_flush = 1'b1;
    step_n();
    check("fl_valid", n_ovalid, 0);
    check("fl_ready", n_ready, 1);
    check("fl_ctrl", n_octrl, 16'h000D);
    check("fl_data", n_odata, 0);
    check("fl_pc_kept", n_opc, 32'h80);
    check("fl_stall", n_stall, 4);
    check("fl_bcnt", n_bcnt, 1);
    n_flush = 1'b0; n_valid = 1'b0; n_iready = 1'b1;
    step_n();
    check("fl_no_ghost", n_ovalid, 0);

    // bubble and flush together: flush wins
    drive_n(1'b1, 32'h90, 50);
    n_bubble = 1'b1; n_flush = 1'b1;
    step_n();
    check("bf_valid", n_ovalid, 0);
    check("bf_bcnt", n_bcnt, 1);
    n_bubble = 1'b0; n_flush = 1'b0; n_valid = 1'b0;

    // reset with skid full, falling-edge stage
    drive_n(1'b1, 32'h300, 60);
    step_n();
    n_iready = 1'b0;
    drive_n(1'b1, 32'h304, 61);
    step_n();
    check("nrs_skid_full", n_ready, 0);
    drive_n(1'b1, 32'h308, 62);
    n_rst = 1'b1;
    step_n();
    check("nrs_valid", n_ovalid, 0);
    check("nrs_ready", n_ready, 0);
    check("nrs_pc", n_opc, 0);
    check("nrs_ctrl", n_octrl, 0);
    check("nrs_stall", n_stall, 0);
    check("nrs_bcnt", n_bcnt, 0);
    n_rst = 1'b0; n_valid = 1'b0; n_iready = 1'b1;
    @(posedge clk); #1;
    check("nrs_inactive_ready", n_ready, 0);
    step_n();
    check("nrs_rel_ready", n_ready, 1);
    check("nrs_rel_valid", n_ovalid, 0);

    // rising-edge stage with 4-bit counters
    p_rst = 1'b0;
    step_p();
    check("p_rel_ready", p_ready, 1);
    p_valid = 1'b1; p_pc = 32'h10; p_data = 8'h5A; p_ctrl = 16'h0123; p_iready = 1'b1;
    @(negedge clk); #1;
    check("p_inactive_valid", p_ovalid, 0);
    step_p();
    check("p_valid", p_ovalid, 1);
    check("p_pc", p_opc, 32'h10);
    check("p_data", p_odata, 8'h5A);
    check("p_ctrl", p_octrl, 16'h0123);
    p_iready = 1'b0; p_pc = 32'h14; p_data = 8'h3C;
    step_p();
    check("p_skid_full", p_ready, 0);
    check("p_stall1", p_stall, 1);
    p_valid = 1'b0;
    for (int i = 2; i <= 20; i++) begin
      step_p();
      if (i == 8)  check("p_stall8", p_stall, 8);
      if (i == 15) check("p_stall15", p_stall, 15);
      if (i == 20) check("p_stall_sat", p_stall, 15);
    end
    p_rst = 1'b1;
    step_p();
    check("prs_valid", p_ovalid, 0);
    check("prs_ready", p_ready, 0);
    check("prs_pc", p_opc, 0);
    check("prs_data", p_odata, 0);
    check("prs_ctrl", p_octrl, 0);
    check("prs_stall", p_stall, 0);
    p_rst = 1'b0; p_iready = 1'b1;
    @(negedge clk); #1;
    check("prs_inactive_ready", p_ready, 0);
    step_p();
    check("prs_rel_ready", p_ready, 1);
    check("prs_rel_valid", p_ovalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
